// File: rtl/pixel_column_adc.sv
// Single-slope ADC back-end for one pixel column: ramp counter, per-pixel code latches, streamed readout.
// Latency: codes are available 2**PIXEL_BITS cycles after start; one word per cycle while out_ready_i is high.
// Backpressure: out_data_o/out_index_o hold while out_valid_o & !out_ready_i; abort_i overrides the handshake.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset (synchronous release expected upstream)
//   start_i        begin a conversion (only honoured in IDLE)
//   abort_i        return to IDLE from CONVERT/READOUT, latches keep their values
//   cmp_i          comparator outputs, 1 = ramp has passed the pixel level (already synchronous)
//   ramp_count_o   digital ramp value driving the ramp DAC
//   busy_o         high in CONVERT or READOUT
//   out_valid_o    readout word available
//   out_ready_i    consumer accepts the word when out_valid_o & out_ready_i
//   out_data_o     latched code of pixel out_index_o
//   out_index_o    pixel number of the current word
//   done_o         one-cycle pulse after the last word is accepted
//   out_sat_o      (only with PIXEL_ADC_SAT_FLAG_EN) current pixel never tripped
//
// Optional feature macro: PIXEL_ADC_SAT_FLAG_EN adds out_sat_o.

module pixel_column_adc #(
    parameter int PIXEL_BITS = 8,
    parameter int NUM_PIXELS = 4,
    localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [NUM_PIXELS-1:0] cmp_i,
    output logic [PIXEL_BITS-1:0] ramp_count_o,
    output logic                  busy_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [PIXEL_BITS-1:0] out_data_o,
    output logic [IDX_W-1:0]      out_index_o,
`ifdef PIXEL_ADC_SAT_FLAG_EN
    output logic                  out_sat_o,
`endif
    output logic                  done_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_READOUT = 2'd2;

    localparam logic [PIXEL_BITS-1:0] RAMP_MAX = {PIXEL_BITS{1'b1}};
    localparam logic [PIXEL_BITS-1:0] RAMP_ONE = {{(PIXEL_BITS-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_PIXELS - 1);
    localparam logic [IDX_W-1:0]      IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    logic [1:0]                                state_q,   state_d;
    logic [PIXEL_BITS-1:0]                     ramp_q,    ramp_d;
    logic [NUM_PIXELS-1:0][PIXEL_BITS-1:0]     latch_q,   latch_d;
    logic [NUM_PIXELS-1:0]                     tripped_q, tripped_d;
    logic [IDX_W-1:0]                          idx_q,     idx_d;
    logic                                      done_q,    done_d;

    always_comb begin
        state_d   = state_q;
        ramp_d    = ramp_q;
        latch_d   = latch_q;
        tripped_d = tripped_q;
        idx_d     = idx_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort_i is meaningless here, so start_i always wins
                if (start_i) begin
                    state_d   = S_CONVERT;
                    ramp_d    = '0;
                    latch_d   = '0;
                    tripped_d = '0;
                    idx_d     = '0;
                end
            end

            S_CONVERT: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    ramp_d  = '0;
                end else begin
                    // Track the ramp until the comparator first goes high; the
                    // sticky tripped bit keeps a comparator that drops back low
                    // from overwriting the code, so the result is count-1 at trip.
                    for (int i = 0; i < NUM_PIXELS; i++) begin
                        if (!tripped_q[i] && !cmp_i[i]) begin
                            latch_d[i] = ramp_q;
                        end
                        if (cmp_i[i]) begin
                            tripped_d[i] = 1'b1;
                        end
                    end
                    if (ramp_q == RAMP_MAX) begin
                        state_d = S_READOUT;
                        ramp_d  = '0;
                        idx_d   = '0;
                    end else begin
                        ramp_d  = ramp_q + RAMP_ONE;
                    end
                end
            end

            S_READOUT: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (out_ready_i) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            ramp_q    <= '0;
            latch_q   <= '0;
            tripped_q <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ramp_q    <= ramp_d;
            latch_q   <= latch_d;
            tripped_q <= tripped_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
        end
    end

    logic in_readout;
    assign in_readout = (state_q == S_READOUT);

    assign ramp_count_o = ramp_q;
    assign busy_o       = (state_q == S_CONVERT) || in_readout;
    assign out_valid_o  = in_readout;
    assign out_index_o  = idx_q;
    assign out_data_o   = in_readout ? latch_q[idx_q] : '0;
    assign done_o       = done_q;

`ifdef PIXEL_ADC_SAT_FLAG_EN
    // A pixel that never tripped saturated at full scale
    assign out_sat_o = in_readout && !tripped_q[idx_q];
`endif

endmodule
